// File: rtl/lsu_dm_port.sv
// Load/store unit to data-memory port: one request at a time, aligned accesses in one
// memory cycle, unaligned ones split into per-byte cycles, illegal sizes answered with an error.
module lsu_dm_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [10:0] dm_a,
  output logic [31:0] dm_wd,
  input  logic [31:0] dm_rd
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_BYTE = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic [12:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] asm_q, asm_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic        dm_we_q, dm_we_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [10:0] dm_a_q, dm_a_d;
  logic [31:0] dm_wd_q, dm_wd_d;
  logic [1:0]  ea_lo_s;
  logic [12:0] ea_next_s;
  logic        unused_s;

  assign unused_s = ^req_addr[31:13];

  function automatic logic [3:0] onehot4(input logic [1:0] off);
    case (off)
      2'd0:    onehot4 = 4'b0001;
      2'd1:    onehot4 = 4'b0010;
      2'd2:    onehot4 = 4'b0100;
      default: onehot4 = 4'b1000;
    endcase
  endfunction

  function automatic logic [7:0] lane8(input logic [31:0] w, input logic [1:0] off);
    case (off)
      2'd0:    lane8 = w[7:0];
      2'd1:    lane8 = w[15:8];
      2'd2:    lane8 = w[23:16];
      default: lane8 = w[31:24];
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [1:0] size, input logic sgn,
                                         input logic [31:0] v);
    case (size)
      2'b00:   extend = {{24{sgn & v[7]}}, v[7:0]};
      2'b01:   extend = {{16{sgn & v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  // Next state, operand latching and load assembly; memory-port and response
  // outputs are derived from the next state so they come straight from flops.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    k_d      = k_q;
    asm_d    = asm_q;
    ea_lo_s  = addr_q[1:0] + k_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr[12:0];
          wdata_d = req_wdata;
          k_d     = 2'd0;
          asm_d   = 32'd0;
          if (req_size == 2'b11) begin
            state_d = S_RESP;
          end else if ((req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                       (req_size == 2'b01 && req_addr[0])) begin
            state_d = S_BYTE;
          end else begin
            state_d = S_ACC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        state_d = S_RESP;
        case (size_q)
          2'b10:   asm_d = dm_rd;
          2'b01:   asm_d = addr_q[1] ? {16'd0, dm_rd[31:16]} : {16'd0, dm_rd[15:0]};
          default: asm_d = {24'd0, lane8(dm_rd, addr_q[1:0])};
        endcase
      end
      S_BYTE: begin
        asm_d[{k_q, 3'b000} +: 8] = lane8(dm_rd, ea_lo_s);
        if ((size_q == 2'b10 && k_q == 2'd3) || (size_q != 2'b10 && k_q == 2'd1)) begin
          state_d = S_RESP;
        end else begin
          k_d = k_q + 2'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    resp_err_d   = (state_d == S_RESP) && (size_d == 2'b11);
    if (state_d == S_RESP && size_d != 2'b11 && !we_d) begin
      resp_rdata_d = extend(size_d, sgn_d, asm_d);
    end else begin
      resp_rdata_d = 32'd0;
    end

    // Effective address wraps inside the 8 KB window by 13-bit truncation.
    ea_next_s = addr_d + {11'd0, k_d};
    dm_we_d   = 1'b0;
    dm_be_d   = 4'b0000;
    dm_a_d    = 11'd0;
    dm_wd_d   = 32'd0;
    case (state_d)
      S_ACC: begin
        dm_a_d = addr_d[12:2];
        if (we_d) begin
          dm_we_d = 1'b1;
          case (size_d)
            2'b10: begin
              dm_be_d = 4'b1111;
              dm_wd_d = wdata_d;
            end
            2'b01: begin
              dm_be_d = addr_d[1] ? 4'b1100 : 4'b0011;
              dm_wd_d = {16'd0, wdata_d[15:0]};
            end
            default: begin
              dm_be_d = onehot4(addr_d[1:0]);
              dm_wd_d = {24'd0, wdata_d[7:0]};
            end
          endcase
        end else begin
          dm_we_d = 1'b0;
        end
      end
      S_BYTE: begin
        dm_a_d = ea_next_s[12:2];
        if (we_d) begin
          dm_we_d = 1'b1;
          dm_be_d = onehot4(ea_next_s[1:0]);
          dm_wd_d = {24'd0, wdata_d[{k_d, 3'b000} +: 8]};
        end else begin
          dm_we_d = 1'b0;
        end
      end
      default: dm_we_d = 1'b0;
    endcase
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      sgn_q        <= 1'b0;
      addr_q       <= 13'd0;
      wdata_q      <= 32'd0;
      k_q          <= 2'd0;
      asm_q        <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      dm_we_q      <= 1'b0;
      dm_be_q      <= 4'b0000;
      dm_a_q       <= 11'd0;
      dm_wd_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      sgn_q        <= sgn_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      k_q          <= k_d;
      asm_q        <= asm_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      dm_we_q      <= dm_we_d;
      dm_be_q      <= dm_be_d;
      dm_a_q       <= dm_a_d;
      dm_wd_q      <= dm_wd_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dm_we      = dm_we_q;
  assign dm_be      = dm_be_q;
  assign dm_a       = dm_a_q;
  assign dm_wd      = dm_wd_q;

endmodule

// File: tb/tb_lsu_dm_port.sv
// Scoreboard bench for lsu_dm_port: directed requests push expected memory writes and
// responses into queues; negedge monitors pop and compare whatever the DUT presents.
module tb_lsu_dm_port;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [10:0] dm_a;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] mem [0:2047];

  typedef struct { logic [31:0] rdata; logic err; int due; } resp_t;
  typedef struct { logic [10:0] a; logic [3:0] be; logic [31:0] wd; } wr_t;
  resp_t rq[$];
  wr_t   wq[$];

  lsu_dm_port dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dm_we(dm_we), .dm_be(dm_be),
    .dm_a(dm_a), .dm_wd(dm_wd), .dm_rd(dm_rd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign dm_rd = mem[dm_a];

  // Memory model: right-justified data placed by byte enable.
  always @(posedge clk) begin
    if (dm_we) begin
      case (dm_be)
        4'b1111: mem[dm_a]        <= dm_wd;
        4'b0011: mem[dm_a][15:0]  <= dm_wd[15:0];
        4'b1100: mem[dm_a][31:16] <= dm_wd[15:0];
        4'b0001: mem[dm_a][7:0]   <= dm_wd[7:0];
        4'b0010: mem[dm_a][15:8]  <= dm_wd[7:0];
        4'b0100: mem[dm_a][23:16] <= dm_wd[7:0];
        4'b1000: mem[dm_a][31:24] <= dm_wd[7:0];
        default: mem[dm_a]        <= mem[dm_a];
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write-port monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (dm_we) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got a=%0d be=%b wd=%h expected none", dm_a, dm_be, dm_wd);
        end else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", {21'd0, dm_a}, {21'd0, w.a});
          chk("wr_be", {28'd0, dm_be}, {28'd0, w.be});
          chk("wr_data", dm_wd, w.wd);
        end
      end else begin
        chk("idle_be", {28'd0, dm_be}, 32'd0);
      end
    end
  end

  // Response monitor.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (rq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got rdata=%h err=%b expected none", resp_rdata, resp_err);
      end else begin
        resp_t r;
        r = rq.pop_front();
        chk("resp_rdata", resp_rdata, r.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, r.err});
        chk("resp_latency", cyc + 1, r.due);
      end
    end
  end

  task automatic push_wr(input logic [10:0] a, input logic [3:0] be, input logic [31:0] wd);
    wr_t w;
    w.a = a; w.be = be; w.wd = wd;
    wq.push_back(w);
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    resp_t r;
    int n;
    @(negedge clk);
    req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    r.rdata = exp_rdata; r.err = exp_err; r.due = cyc + lat;
    rq.push_back(r);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = ~we; req_size = ~size; req_addr = ~addr; req_wdata = ~wdata; req_signed = ~sgn;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1 within 20 cycles");
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_dm_we", {31'd0, dm_we}, 32'd0);
    chk("rst_dm_be", {28'd0, dm_be}, 32'd0);
    chk("rst_dm_a", {21'd0, dm_a}, 32'd0);
    chk("rst_dm_wd", dm_wd, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Aligned word / half traffic.
    push_wr(11'd4, 4'b1111, 32'hDEADBEEF);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 32'd0, 1'b0, 2);
    push_wr(11'd1, 4'b1100, 32'h0000A5C3);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0006, 32'h0000A5C3, 32'd0, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_0006, 32'd0, 32'hFFFFA5C3, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0006, 32'd0, 32'h0000A5C3, 1'b0, 2);
    issue(1'b0, 2'b10, 1'b1, 32'h0000_0010, 32'd0, 32'hDEADBEEF, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'd0, 32'hFFFFFFAD, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'd0, 32'h000000DE, 1'b0, 2);

    // Unaligned word store and reload.
    push_wr(11'd0, 4'b0010, 32'h44);
    push_wr(11'd0, 4'b0100, 32'h33);
    push_wr(11'd0, 4'b1000, 32'h22);
    push_wr(11'd1, 4'b0001, 32'h11);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0001, 32'h11223344, 32'd0, 1'b0, 5);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'd0, 32'h11223344, 1'b0, 5);

    // Wrap across the top of the 8 KB window.
    push_wr(11'd2047, 4'b1000, 32'h80);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_1FFF, 32'h00000080, 32'd0, 1'b0, 2);
    push_wr(11'd0, 4'b0001, 32'h7F);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0000, 32'h0000007F, 32'd0, 1'b0, 2);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_1FFF, 32'd0, 32'h00007F80, 1'b0, 3);
    push_wr(11'd2047, 4'b1000, 32'hEF);
    push_wr(11'd0, 4'b0001, 32'hBE);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_1FFF, 32'h0000BEEF, 32'd0, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_1FFF, 32'd0, 32'hFFFFBEEF, 1'b0, 3);

    // Illegal size, load and store: error, no writes.
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'd0, 32'd0, 1'b1, 1);
    issue(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h12345678, 32'd0, 1'b1, 1);

    // Upper address bits are ignored.
    push_wr(11'd2, 4'b1111, 32'h0BADF00D);
    issue(1'b1, 2'b10, 1'b0, 32'hFFFF_E008, 32'h0BADF00D, 32'd0, 1'b0, 2);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'd0, 32'h0BADF00D, 1'b0, 2);

    // Reset in the second byte cycle of an unaligned store.
    push_wr(11'h040, 4'b0010, 32'h0D);
    @(negedge clk);
    req_we = 1'b1; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0000_0101; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort_dm_we", {31'd0, dm_we}, 32'd0);
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0, 32'h00000D00, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("resp_queue_empty", rq.size(), 32'd0);
    chk("write_queue_empty", wq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
